ball_motion: RTL and testbench

Ball motion generator for the bounce-ball game. It owns the ball position registers `ball_x_reg` and `ball_y_reg` and advances them once per video frame. On each frame it bounces the ball off the screen walls and the player paddle, and it handles serve and miss sequencing. Its position outputs feed the downstream collision/flag stage, and the single-cycle hit pulse from that stage comes back in as `hit_in` to reverse vertical direction.

---
 rtl/ball_motion.sv | 168 ++++++++++++++++
 tb/tb_ball_motion.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball motion generator: owns the ball position/direction registers and steps
// them once per frame, handling wall/paddle bounces, hit feedback and serve/miss.
module ball_motion #(
  parameter int BALL_SIZE = 8,
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480,
  parameter int SPEED     = 2,
  parameter int SERVE_X   = 316,
  parameter int SERVE_Y   = 240,
  parameter int MISS_HOLD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic       hit_in,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  input  logic [9:0] paddle_h_size,
  output logic [9:0] ball_x_reg,
  output logic [9:0] ball_y_reg,
  output logic       ball_dx,
  output logic       ball_dy,
  output logic       ball_active,
  output logic       paddle_hit,
  output logic       miss
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] MISS = 2'd2;

  localparam logic [10:0] SZ        = 11'(BALL_SIZE);
  localparam logic [10:0] SP        = 11'(SPEED);
  localparam logic [10:0] HMAX      = 11'(H_MAX);
  localparam logic [10:0] VMAX      = 11'(V_MAX);
  localparam logic [9:0]  X_RIGHT   = 10'(H_MAX - BALL_SIZE);
  localparam logic [9:0]  X_SERVE   = 10'(SERVE_X);
  localparam logic [9:0]  Y_SERVE   = 10'(SERVE_Y);
  localparam logic [7:0]  HOLD_LAST = 8'(MISS_HOLD - 1);

  logic [1:0]  state, state_next;
  logic [7:0]  miss_cnt, cnt_next;
  logic        hit_latch, hit_latch_next;
  logic [9:0]  x_next, y_next;
  logic        dx_next, dy_next;
  logic        paddle_hit_next, miss_next;

  // Everything is evaluated at 11 bits so edge sums never wrap.
  logic [10:0] x_ext, y_ext, x_inc, x_dec, y_inc, y_dec;
  logic [10:0] ball_right, ball_bottom, paddle_left, paddle_right, paddle_top;
  logic        hit_pending, over_paddle, near_paddle;

  always_comb begin
    x_ext        = {1'b0, ball_x_reg};
    y_ext        = {1'b0, ball_y_reg};
    x_inc        = x_ext + SP;
    x_dec        = x_ext - SP;
    y_inc        = y_ext + SP;
    y_dec        = y_ext - SP;
    ball_right   = x_ext + SZ - 11'd1;
    ball_bottom  = y_ext + SZ;
    paddle_left  = {1'b0, paddle_x};
    paddle_right = {1'b0, paddle_x} + {1'b0, paddle_h_size} - 11'd1;
    paddle_top   = {1'b0, paddle_y};
    over_paddle  = (ball_right >= paddle_left) && (x_ext <= paddle_right);
    near_paddle  = (ball_bottom <= paddle_top) && (ball_bottom + SP >= paddle_top);
    hit_pending  = hit_latch | hit_in;
  end

  // Next-state logic; all motion is gated by frame_tick.
  always_comb begin
    state_next      = state;
    cnt_next        = miss_cnt;
    hit_latch_next  = 1'b0;
    x_next          = ball_x_reg;
    y_next          = ball_y_reg;
    dx_next         = ball_dx;
    dy_next         = ball_dy;
    paddle_hit_next = 1'b0;
    miss_next       = 1'b0;

    case (state)
      IDLE: begin
        x_next = X_SERVE;
        y_next = Y_SERVE;
        if (serve) state_next = MOVE;
      end

      MOVE: begin
        hit_latch_next = hit_pending;
        if (frame_tick) begin
          hit_latch_next = 1'b0;

          if (!ball_dx && x_ext <= SP) begin
            x_next  = 10'd0;
            dx_next = 1'b1;
          end else if (ball_dx && (x_ext + SZ + SP >= HMAX)) begin
            x_next  = X_RIGHT;
            dx_next = 1'b0;
          end else begin
            x_next = ball_dx ? x_inc[9:0] : x_dec[9:0];
          end

          if (ball_dy && over_paddle && near_paddle) begin
            y_next          = 10'(paddle_top - SZ);
            dy_next         = 1'b0;
            paddle_hit_next = 1'b1;
          end else if (ball_dy && (y_ext + SP >= VMAX)) begin
            state_next = MISS;
            miss_next  = 1'b1;
            x_next     = X_SERVE;
            y_next     = Y_SERVE;
            dx_next    = 1'b1;
            dy_next    = 1'b0;
            cnt_next   = 8'd0;
          end else if (!ball_dy && y_ext <= SP) begin
            y_next  = 10'd0;
            dy_next = 1'b1;
          end else if (hit_pending) begin
            dy_next = ~ball_dy;
            y_next  = ball_dy ? y_dec[9:0] : y_inc[9:0];
          end else begin
            y_next = ball_dy ? y_inc[9:0] : y_dec[9:0];
          end
        end
      end

      MISS: begin
        x_next = X_SERVE;
        y_next = Y_SERVE;
        if (frame_tick) begin
          cnt_next = miss_cnt + 8'd1;
          if (miss_cnt == HOLD_LAST) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      miss_cnt    <= 8'd0;
      hit_latch   <= 1'b0;
      ball_x_reg  <= X_SERVE;
      ball_y_reg  <= Y_SERVE;
      ball_dx     <= 1'b1;
      ball_dy     <= 1'b0;
      ball_active <= 1'b0;
      paddle_hit  <= 1'b0;
      miss        <= 1'b0;
    end else begin
      state       <= state_next;
      miss_cnt    <= cnt_next;
      hit_latch   <= hit_latch_next;
      ball_x_reg  <= x_next;
      ball_y_reg  <= y_next;
      ball_dx     <= dx_next;
      ball_dy     <= dy_next;
      ball_active <= (state_next == MOVE);
      paddle_hit  <= paddle_hit_next;
      miss        <= miss_next;
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: walks one ball through serve, hit feedback,
// paddle, wall, top, miss and re-serve with hand-computed positions.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       serve;
  logic       hit_in;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic [9:0] paddle_h_size;
  logic [9:0] ball_x_reg;
  logic [9:0] ball_y_reg;
  logic       ball_dx;
  logic       ball_dy;
  logic       ball_active;
  logic       paddle_hit;
  logic       miss;

  int checkCount = 0;
  int passCount  = 0;

  ball_motion dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .serve         (serve),
    .hit_in        (hit_in),
    .paddle_x      (paddle_x),
    .paddle_y      (paddle_y),
    .paddle_h_size (paddle_h_size),
    .ball_x_reg    (ball_x_reg),
    .ball_y_reg    (ball_y_reg),
    .ball_dx       (ball_dx),
    .ball_dy       (ball_dy),
    .ball_active   (ball_active),
    .paddle_hit    (paddle_hit),
    .miss          (miss)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic checkBall(input string tag, input int x, input int y, input int dx, input int dy);
    checkOutput($sformatf("%s.x", tag), int'(ball_x_reg), x);
    checkOutput($sformatf("%s.y", tag), int'(ball_y_reg), y);
    checkOutput($sformatf("%s.dx", tag), int'(ball_dx), dx);
    checkOutput($sformatf("%s.dy", tag), int'(ball_dy), dy);
  endtask

  // Each tick is a single-cycle pulse; on return the update edge has passed.
  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic applyHit();
    @(negedge clk);
    hit_in = 1'b1;
    @(negedge clk);
    hit_in = 1'b0;
  endtask

  task automatic applyServe();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  task automatic paddleAway();
    paddle_x      = 10'd0;
    paddle_y      = 10'd0;
    paddle_h_size = 10'd1;
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    hit_in     = 1'b0;
    paddleAway();

    #12;
    checkBall("reset", 316, 240, 1, 0);
    checkOutput("reset.active", int'(ball_active), 0);
    checkOutput("reset.paddle_hit", int'(paddle_hit), 0);
    checkOutput("reset.miss", int'(miss), 0);
    @(negedge clk);
    rst = 1'b0;

    applyServe();
    checkOutput("serve.active", int'(ball_active), 1);
    checkBall("serve.hold", 316, 240, 1, 0);
    applyTicks(1);
    checkBall("first_move", 318, 238, 1, 0);

    #2 rst = 1'b1;
    #1;
    checkBall("async_rst", 316, 240, 1, 0);
    checkOutput("async_rst.active", int'(ball_active), 0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    serve      = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    serve      = 1'b0;
    frame_tick = 1'b0;
    checkOutput("serve_tick.active", int'(ball_active), 1);
    checkBall("serve_tick", 316, 240, 1, 0);
    applyTicks(1);
    checkBall("reserve_move", 318, 238, 1, 0);

    applyTicks(19);
    checkBall("pre_hit", 356, 200, 1, 0);
    applyHit();
    checkOutput("hit_midframe.y", int'(ball_y_reg), 200);
    applyTicks(1);
    checkBall("hit_reverse", 358, 202, 1, 1);
    applyTicks(1);
    checkBall("hit_cleared", 360, 204, 1, 1);

    applyTicks(113);
    checkBall("pre_paddle", 586, 430, 1, 1);
    paddle_x      = 10'd560;
    paddle_y      = 10'd440;
    paddle_h_size = 10'd26;
    applyTicks(1);
    checkBall("paddle_miss_edge", 588, 432, 1, 1);
    checkOutput("paddle_miss_edge.pulse", int'(paddle_hit), 0);
    paddle_h_size = 10'd29;
    applyTicks(1);
    checkBall("paddle_bounce", 590, 432, 1, 0);
    checkOutput("paddle_bounce.pulse", int'(paddle_hit), 1);
    @(negedge clk);
    checkOutput("paddle_bounce.pulse_end", int'(paddle_hit), 0);
    paddleAway();

    applyTicks(20);
    checkBall("pre_right", 630, 392, 1, 0);
    applyTicks(1);
    checkBall("right_wall", 632, 390, 0, 0);
    applyTicks(1);
    checkBall("right_after", 630, 388, 0, 0);

    applyTicks(193);
    checkBall("pre_top", 244, 2, 0, 0);
    applyHit();
    applyTicks(1);
    checkBall("top_wins", 242, 0, 0, 1);
    applyTicks(1);
    checkBall("top_latch_clear", 240, 2, 0, 1);

    applyTicks(119);
    checkBall("pre_left", 2, 240, 0, 1);
    applyTicks(1);
    checkBall("left_wall", 0, 242, 1, 1);

    applyTicks(118);
    checkBall("pre_bottom", 236, 478, 1, 1);
    checkOutput("pre_bottom.miss", int'(miss), 0);
    applyTicks(1);
    checkOutput("bottom.miss", int'(miss), 1);
    checkOutput("bottom.active", int'(ball_active), 0);
    checkBall("bottom", 316, 240, 1, 0);
    @(negedge clk);
    checkOutput("bottom.miss_end", int'(miss), 0);

    applyTicks(59);
    checkBall("miss_hold", 316, 240, 1, 0);
    applyServe();
    checkOutput("miss_serve_ignored", int'(ball_active), 0);
    applyTicks(1);
    applyServe();
    checkOutput("idle_reserve.active", int'(ball_active), 1);
    checkBall("idle_reserve", 316, 240, 1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
